sum_accum: RTL and testbench

SUM_ACCUM -- requirements
Module: sum_accum

---
 rtl/sum_accum_pkg.sv | 15 +
 rtl/sum_accum_sat_add.sv | 35 +++
 rtl/sum_accum.sv | 101 ++++++++++
 tb/tb_sum_accum.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/sum_accum_pkg.sv
// Shared definitions for the sum accumulator.
// - state_t : frame FSM state (ACCUM collects sums, HOLD presents the result)
// - N_DEF/M_DEF/W_DEF : default operand width, sums per frame, result width
package sum_accum_pkg;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  localparam int N_DEF = 4;
  localparam int M_DEF = 4;
  localparam int W_DEF = 6;

endpackage

// File: rtl/sum_accum_sat_add.sv
// Combinational signed saturating adder.
// Ports:
//   a, b : signed W-bit addends
//   sum  : a+b clipped to the signed W-bit range
//   clip : 1 when the exact sum did not fit and was clipped
module sat_add
  import sum_accum_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic signed [W-1:0] a,
  input  logic signed [W-1:0] b,
  output logic signed [W-1:0] sum,
  output logic                clip
);

  // Overflow of a W+1-bit sum of two sign-extended W-bit values shows up as
  // the top two bits disagreeing; the top bit then gives the true sign.
  function automatic logic clip_w(input logic signed [W:0] x);
    return x[W] != x[W-1];
  endfunction

  function automatic logic signed [W-1:0] sat_w(input logic signed [W:0] x);
    if (clip_w(x))
      return x[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    return x[W-1:0];
  endfunction

  logic signed [W:0] wide;

  assign wide = (W+1)'(a) + (W+1)'(b);
  assign sum  = sat_w(wide);
  assign clip = clip_w(wide);

endmodule

// File: rtl/sum_accum.sv
// Frame accumulator: sums M signed words from the upstream adder with
// saturation, then presents the frame result until it is handshaked.
// Ports:
//   clk, rst           : rising-edge clock, async active-high reset
//   clr                : synchronous frame abort (drops partial/pending result)
//   S, in_valid        : signed n+1-bit input word and its valid
//   in_ready           : high while collecting (ACCUM)
//   out_data, out_sat  : signed W-bit result and "clipped during frame" flag
//   out_valid          : high while the result is presented (HOLD)
//   out_ready          : downstream accepts the result
module sum_accum
  import sum_accum_pkg::*;
#(
  parameter int n = N_DEF,
  parameter int M = M_DEF,
  parameter int W = W_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clr,
  input  logic signed [n:0]   S,
  input  logic                in_valid,
  output logic                in_ready,
  output logic signed [W-1:0] out_data,
  output logic                out_sat,
  output logic                out_valid,
  input  logic                out_ready
);

  localparam int CW = $clog2(M);
  localparam logic [CW-1:0] CNT_LAST = CW'(M - 1);

  state_t              state_p1, state_nx;
  logic signed [W-1:0] acc_p1, acc_nx;
  logic [CW-1:0]       cnt_p1, cnt_nx;
  logic                sat_p1, sat_nx;

  logic signed [W-1:0] s_ext;
  logic signed [W-1:0] add_sum;
  logic                add_clip;

  assign s_ext = W'(S);

  sat_add #(.W(W)) u_sat_add (
    .a    (acc_p1),
    .b    (s_ext),
    .sum  (add_sum),
    .clip (add_clip)
  );

  always_comb begin
    state_nx = state_p1;
    acc_nx   = acc_p1;
    cnt_nx   = cnt_p1;
    sat_nx   = sat_p1;
    if (clr) begin
      // Abort wins over any transfer or handshake on the same edge.
      state_nx = ACCUM;
      acc_nx   = '0;
      cnt_nx   = '0;
      sat_nx   = 1'b0;
    end else if (state_p1 == ACCUM) begin
      if (in_valid) begin
        acc_nx = add_sum;
        sat_nx = sat_p1 | add_clip;
        if (cnt_p1 == CNT_LAST) begin
          // cnt parks at M-1 while the result is held.
          state_nx = HOLD;
        end else begin
          cnt_nx = cnt_p1 + CW'(1);
        end
      end
    end else if (out_ready) begin
      state_nx = ACCUM;
      acc_nx   = '0;
      cnt_nx   = '0;
      sat_nx   = 1'b0;
    end
  end

  // ---- stage p1: frame state register ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_p1 <= ACCUM;
      acc_p1   <= '0;
      cnt_p1   <= '0;
      sat_p1   <= 1'b0;
    end else begin
      state_p1 <= state_nx;
      acc_p1   <= acc_nx;
      cnt_p1   <= cnt_nx;
      sat_p1   <= sat_nx;
    end
  end

  assign in_ready  = (state_p1 == ACCUM);
  assign out_valid = (state_p1 == HOLD);
  assign out_data  = acc_p1;
  assign out_sat   = sat_p1;

endmodule

// File: tb/tb_sum_accum.sv
module tb_sum_accum;

  localparam int n = 4;
  localparam int M = 4;
  localparam int W = 6;
  localparam int SMAX = 31;
  localparam int SMIN = -32;

  logic                clk;
  logic                rst;
  logic                clr;
  logic signed [n:0]   S;
  logic                in_valid;
  logic                in_ready;
  logic signed [W-1:0] out_data;
  logic                out_sat;
  logic                out_valid;
  logic                out_ready;

  sum_accum #(.n(n), .M(M), .W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr),
    .S         (S),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_sat   (out_sat),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int data;
    int sat;
  } res_t;

  res_t q[$];
  int   nvec = 0;
  int   nerr = 0;
  int   frames = 0;
  bit   mhold = 1'b0;
  int   macc = 0;
  int   mcnt = 0;
  bit   mflag = 1'b0;
  int   last_data = 0;
  int   last_sat = 0;

  task automatic check(input string tag, input int got, input int exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int sat6(input int x);
    if (x > SMAX) return SMAX;
    if (x < SMIN) return SMIN;
    return x;
  endfunction

  task automatic model_clear();
    mhold = 1'b0;
    macc  = 0;
    mcnt  = 0;
    mflag = 1'b0;
  endtask

  // One clock cycle: drive at negedge, check outputs, advance the model.
  task automatic step(input bit v, input int s, input bit ordy, input bit c);
    int t;
    @(negedge clk);
    in_valid  = v;
    S         = (n+1)'(s);
    out_ready = ordy;
    clr       = c;
    #1;
    check("in_ready", int'(in_ready), int'(!mhold));
    check("out_valid", int'(out_valid), int'(mhold));
    if (mhold && q.size() > 0) begin
      check("out_data", int'(out_data), q[0].data);
      check("out_sat", int'(out_sat), q[0].sat);
    end
    if (c) begin
      if (mhold && q.size() > 0) void'(q.pop_front());
      model_clear();
    end else if (!mhold) begin
      if (v) begin
        t     = macc + s;
        macc  = sat6(t);
        mflag = mflag | (t != macc);
        mcnt++;
        if (mcnt == M) begin
          q.push_back('{macc, int'(mflag)});
          mhold = 1'b1;
        end
      end
    end else if (ordy) begin
      last_data = int'(out_data);
      last_sat  = int'(out_sat);
      if (q.size() > 0) void'(q.pop_front());
      frames++;
      model_clear();
    end
  endtask

  task automatic frame(input int s, input bit ordy);
    for (int i = 0; i < M; i++) step(1'b1, s, ordy, 1'b0);
  endtask

  task automatic async_reset(input string tag);
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    clr       = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check({tag, "_in_ready"}, int'(in_ready), 1);
    check({tag, "_out_valid"}, int'(out_valid), 0);
    check({tag, "_out_data"}, int'(out_data), 0);
    check({tag, "_out_sat"}, int'(out_sat), 0);
    @(negedge clk);
    rst = 1'b0;
    q.delete();
    model_clear();
  endtask

  initial begin
    int f0;
    int cyc;
    rst       = 1'b1;
    clr       = 1'b0;
    S         = '0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_data", int'(out_data), 0);
    check("rst_out_sat", int'(out_sat), 0);
    rst = 1'b0;

    // Basic frame, continuous valid.
    step(1, 7, 1, 0);
    step(1, 3, 1, 0);
    step(1, -2, 1, 0);
    step(1, 0, 1, 0);
    step(0, 0, 1, 0);
    check("basic_data", last_data, 8);
    check("basic_sat", last_sat, 0);

    // Positive and negative saturation.
    frame(15, 1);
    step(0, 0, 1, 0);
    check("satpos_data", last_data, 31);
    check("satpos_sat", last_sat, 1);
    frame(-16, 1);
    step(0, 0, 1, 0);
    check("satneg_data", last_data, -32);
    check("satneg_sat", last_sat, 1);

    // Backpressure in HOLD with in_valid held; pending word is not consumed.
    frame(1, 0);
    for (int i = 0; i < 5; i++) step(1, 9, 0, 0);
    step(1, 9, 1, 0);
    check("hold_data", last_data, 4);
    frame(9, 1);
    step(0, 0, 1, 0);
    check("next_data", last_data, 31);
    check("next_sat", last_sat, 1);

    // Abort after two transfers.
    step(1, 5, 1, 0);
    step(1, 5, 1, 0);
    step(0, 0, 1, 1);
    frame(1, 1);
    step(0, 0, 1, 0);
    check("clr_data", last_data, 4);
    check("clr_sat", last_sat, 0);

    // Abort on the same edge as a transfer: sample dropped.
    step(1, 7, 1, 1);
    frame(1, 1);
    step(0, 0, 1, 0);
    check("clrx_data", last_data, 4);

    // Abort together with an output handshake in HOLD.
    frame(3, 0);
    step(0, 0, 1, 1);
    frame(2, 1);
    step(0, 0, 1, 0);
    check("clrh_data", last_data, 8);

    // Async reset mid-frame and in HOLD.
    step(1, 2, 0, 0);
    step(1, 2, 0, 0);
    async_reset("rst_mid");
    frame(2, 1);
    step(0, 0, 1, 0);
    check("rst_mid_next", last_data, 8);
    frame(5, 0);
    async_reset("rst_hold");
    frame(2, 1);
    step(0, 0, 1, 0);
    check("rst_hold_next", last_data, 8);

    // Random gaps on both sides, occasional abort.
    f0  = frames;
    cyc = 0;
    while (frames - f0 < 100 && cyc < 20000) begin
      step($urandom_range(0, 9) < 7,
           int'($urandom_range(0, 31)) - 16,
           $urandom_range(0, 9) < 6,
           $urandom_range(0, 49) == 0);
      cyc++;
    end
    check("rand_frames", frames - f0, 100);
    step(0, 0, 1, 0);
    step(0, 0, 1, 0);
    check("queue_left", q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
